// File: rtl/id_register_file_if.sv
// Bundles the ID-stage register file's WB write, ID read, bypass select and debug signals.
// master drives writes/addresses/selects; slave is the register file.
interface id_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  RegWrite_wb;
    logic [ADDR_WIDTH-1:0] RegWriteAddr_wb;
    logic [DATA_WIDTH-1:0] RegWriteData_wb;
    logic [ADDR_WIDTH-1:0] RsAddr_id;
    logic [ADDR_WIDTH-1:0] RtAddr_id;
    logic                  RsSel;
    logic                  RtSel;
    logic [DATA_WIDTH-1:0] RsData_id;
    logic [DATA_WIDTH-1:0] RtData_id;
    logic [ADDR_WIDTH-1:0] DbgAddr;
    logic [DATA_WIDTH-1:0] DbgData;
    logic [15:0]           WriteCount;

    modport master (
        output RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
        output RsAddr_id, RtAddr_id, RsSel, RtSel, DbgAddr,
        input  RsData_id, RtData_id, DbgData, WriteCount
    );

    modport slave (
        input  RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
        input  RsAddr_id, RtAddr_id, RsSel, RtSel, DbgAddr,
        output RsData_id, RtData_id, DbgData, WriteCount
    );
endinterface

// File: rtl/id_register_file.sv
// 32-entry MIPS ID-stage register file: WB writes on clk, combinational rs/rt reads with
// WB-to-ID bypass, unbypassed debug read port, and a count of committed writes.
module id_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    id_register_file_if.slave  rf
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [15:0]           count_q;
    logic [15:0]           count_d;
    logic                  wr_en;

    // Writes to r0 are dropped here, so regs_q[0] stays at its reset value of zero.
    assign wr_en = rf.RegWrite_wb && (rf.RegWriteAddr_wb != '0);

    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        if (wr_en) begin
            regs_d[rf.RegWriteAddr_wb] = rf.RegWriteData_wb;
            count_d                    = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        rf.RsData_id = '0;
        rf.RtData_id = '0;
        rf.DbgData   = '0;
        if (rf.RsSel) begin
            rf.RsData_id = rf.RegWriteData_wb;
        end else if (rf.RsAddr_id != '0) begin
            rf.RsData_id = regs_q[rf.RsAddr_id];
        end
        if (rf.RtSel) begin
            rf.RtData_id = rf.RegWriteData_wb;
        end else if (rf.RtAddr_id != '0) begin
            rf.RtData_id = regs_q[rf.RtAddr_id];
        end
        if (rf.DbgAddr != '0) begin
            rf.DbgData = regs_q[rf.DbgAddr];
        end
    end

    assign rf.WriteCount = count_q;
endmodule
